// File: rtl/nes_pad_responder_if.sv
// ============================================================================
// Module      : nes_pad_responder_if
// Description : Controller-port bundle between a NES/SNES host reader and pad.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nes_pad_responder_if #(
   parameter int NUM_BITS = 8
);
   logic                ctrl_latch;
   logic                ctrl_pulse;
   logic [NUM_BITS-1:0] buttons;
   logic                ctrl_data;
   logic [4:0]          bit_count;
   logic                frame_done;
   logic                proto_err;
   logic [1:0]          state;

   modport master (
      output ctrl_latch, ctrl_pulse, buttons,
      input  ctrl_data, bit_count, frame_done, proto_err, state
   );

   modport slave (
      input  ctrl_latch, ctrl_pulse, buttons,
      output ctrl_data, bit_count, frame_done, proto_err, state
   );
endinterface

`default_nettype wire

// File: rtl/nes_pad_responder.sv
// ============================================================================
// Module      : nes_pad_responder
// Description : Pad-side NES/SNES serial responder answering latch/pulse strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_pad_responder #(
   parameter int   NUM_BITS = 8,
   parameter logic FILL     = 1'b0,
   parameter int   TIMEOUT  = 4096
) (
   input  wire logic           clk,
   input  wire logic           reset,
   nes_pad_responder_if.slave  bus
);

   localparam int                   c_tmo_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   localparam logic [c_tmo_w-1:0]   c_tmo_one  = c_tmo_w'(1);
   localparam logic [4:0]           c_last     = 5'(NUM_BITS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      DRAINED = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_latch_m, r_latch_s;
   logic                r_pulse_m, r_pulse_s, r_pulse_d;
   logic [NUM_BITS-1:0] r_sreg;
   logic                r_ctrl_data;
   logic [4:0]          r_bit_count;
   logic                r_frame_done;
   logic                r_proto_err;
   logic [c_tmo_w-1:0]  r_tmo;

   logic                w_pulse_rise;
   logic [NUM_BITS-1:0] w_shifted;

   assign w_pulse_rise = r_pulse_s & ~r_pulse_d;

   always_comb begin
      w_shifted               = r_sreg >> 1;
      w_shifted[NUM_BITS-1]   = FILL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_latch_m    <= 1'b0;
         r_latch_s    <= 1'b0;
         r_pulse_m    <= 1'b0;
         r_pulse_s    <= 1'b0;
         r_pulse_d    <= 1'b0;
         r_sreg       <= '1;
         r_ctrl_data  <= 1'b1;
         r_bit_count  <= 5'd0;
         r_frame_done <= 1'b0;
         r_proto_err  <= 1'b0;
         r_tmo        <= '0;
      end else begin
         r_latch_m    <= bus.ctrl_latch;
         r_latch_s    <= r_latch_m;
         r_pulse_m    <= bus.ctrl_pulse;
         r_pulse_s    <= r_pulse_m;
         r_pulse_d    <= r_pulse_s;
         r_ctrl_data  <= r_sreg[0];
         r_frame_done <= 1'b0;
         r_proto_err  <= 1'b0;

         // Latch overrides everything; only a pulse during an established load is an error.
         if (r_latch_s) begin
            r_state     <= LOAD;
            r_sreg      <= ~bus.buttons;
            r_bit_count <= 5'd0;
            r_tmo       <= '0;
            if (r_state == LOAD && w_pulse_rise)
               r_proto_err <= 1'b1;
         end else begin
            case (r_state)
               LOAD: begin
                  r_state <= SHIFT;
                  r_tmo   <= '0;
               end
               SHIFT: begin
                  if (w_pulse_rise) begin
                     r_sreg      <= w_shifted;
                     r_bit_count <= r_bit_count + 5'd1;
                     r_tmo       <= '0;
                     if (r_bit_count + 5'd1 == c_last) begin
                        r_state      <= DRAINED;
                        r_frame_done <= 1'b1;
                     end
                  end else if (r_tmo >= c_tmo_last) begin
                     r_state     <= IDLE;
                     r_proto_err <= 1'b1;
                     r_sreg      <= '1;
                     r_bit_count <= 5'd0;
                     r_tmo       <= '0;
                  end else begin
                     r_tmo <= r_tmo + c_tmo_one;
                  end
               end
               DRAINED: begin
                  if (w_pulse_rise)
                     r_sreg <= w_shifted;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.ctrl_data  = r_ctrl_data;
   assign bus.bit_count  = r_bit_count;
   assign bus.frame_done = r_frame_done;
   assign bus.proto_err  = r_proto_err;
   assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
// ============================================================================
// Module      : tb_nes_pad_responder
// Description : Self-checking bench for nes_pad_responder (NES and SNES builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_pad_responder;

   localparam int TMO = 200;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nes_pad_responder_if #(.NUM_BITS(8))  n_if ();
   nes_pad_responder_if #(.NUM_BITS(16)) s_if ();

   nes_pad_responder #(.NUM_BITS(8), .FILL(1'b0), .TIMEOUT(TMO)) u_nes (
      .clk   (clk),
      .reset (reset),
      .bus   (n_if.slave)
   );

   nes_pad_responder #(.NUM_BITS(16), .FILL(1'b0), .TIMEOUT(TMO)) u_snes (
      .clk   (clk),
      .reset (reset),
      .bus   (s_if.slave)
   );

   int          n_checks = 0;
   int          n_errs   = 0;
   int          fd_cnt[2] = '{0, 0};
   int          pe_cnt[2] = '{0, 0};
   logic [15:0] m[2];
   logic        exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic data_of(input int sel);
      return (sel != 0) ? s_if.ctrl_data : n_if.ctrl_data;
   endfunction
   function automatic logic [4:0] bc_of(input int sel);
      return (sel != 0) ? s_if.bit_count : n_if.bit_count;
   endfunction
   function automatic logic [1:0] st_of(input int sel);
      return (sel != 0) ? s_if.state : n_if.state;
   endfunction
   function automatic int nb(input int sel);
      return (sel != 0) ? 16 : 8;
   endfunction

   task automatic set_latch(input int sel, input logic v);
      if (sel != 0) s_if.ctrl_latch = v; else n_if.ctrl_latch = v;
   endtask
   task automatic set_pulse(input int sel, input logic v);
      if (sel != 0) s_if.ctrl_pulse = v; else n_if.ctrl_pulse = v;
   endtask
   task automatic set_buttons(input int sel, input logic [15:0] b);
      if (sel != 0) s_if.buttons = b; else n_if.buttons = b[7:0];
   endtask

   task automatic model_load(input int sel, input logic [15:0] b);
      m[sel] = ~b;
   endtask
   task automatic model_shift(input int sel);
      m[sel] = m[sel] >> 1;
      m[sel][nb(sel)-1] = 1'b0;
   endtask

   // Pin rises just before edge k; data must hold through k+2 and change at k+3.
   task automatic pulse_bit(input int sel, input logic exp_prev, input logic exp_new, input string tag);
      exp_q.push_back(exp_new);
      @(negedge clk);
      set_pulse(sel, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 check_eq({tag, "_early"}, data_of(sel), exp_prev);
      @(posedge clk);
      #1 check_eq(tag, data_of(sel), exp_q.pop_front());
      repeat (3) @(negedge clk);
      set_pulse(sel, 1'b0);
      repeat (6) @(negedge clk);
   endtask

   task automatic shift_pulse(input int sel, input string tag);
      logic prev;
      prev = m[sel][0];
      model_shift(sel);
      pulse_bit(sel, prev, m[sel][0], tag);
   endtask

   task automatic do_latch(input int sel, input int hold, input logic [15:0] b);
      set_buttons(sel, b);
      @(negedge clk);
      set_latch(sel, 1'b1);
      repeat (hold) @(negedge clk);
      set_latch(sel, 1'b0);
      model_load(sel, b);
      repeat (4) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (n_if.frame_done) begin
         fd_cnt[0]++;
         check_eq("nes_fd_bc", n_if.bit_count, 8);
      end
      if (s_if.frame_done) begin
         fd_cnt[1]++;
         check_eq("snes_fd_bc", s_if.bit_count, 16);
      end
      if (n_if.proto_err) pe_cnt[0]++;
      if (s_if.proto_err) pe_cnt[1]++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0, pe0;
      reset = 1'b0;
      n_if.ctrl_latch = 1'b0; n_if.ctrl_pulse = 1'b0; n_if.buttons = '0;
      s_if.ctrl_latch = 1'b0; s_if.ctrl_pulse = 1'b0; s_if.buttons = '0;
      m[0] = '1; m[1] = '1;
      repeat (5) @(negedge clk);
      check_eq("rst_data", data_of(0), 1);
      check_eq("rst_bc", bc_of(0), 0);
      check_eq("rst_state", st_of(0), 0);
      check_eq("rst_snes_data", data_of(1), 1);
      reset = 1'b1;

      // Pulses with no latch are ignored
      repeat (4) pulse_bit(0, 1'b1, 1'b1, "idle_data");
      check_eq("idle_state", st_of(0), 0);
      check_eq("idle_perr", pe_cnt[0], 0);

      // Basic NES frame plus two drain pulses
      do_latch(0, 12, 16'h0085);
      check_eq("nes_shift_state", st_of(0), 2);
      check_eq("nes_bit0", data_of(0), m[0][0]);
      fd0 = fd_cnt[0];
      pe0 = pe_cnt[0];
      repeat (8) shift_pulse(0, "nes_bit");
      check_eq("nes_fd_once", fd_cnt[0] - fd0, 1);
      check_eq("nes_bc", bc_of(0), 8);
      check_eq("nes_drained", st_of(0), 3);
      repeat (2) shift_pulse(0, "drain_fill");
      check_eq("drain_bc", bc_of(0), 8);
      check_eq("drain_state", st_of(0), 3);
      check_eq("drain_perr", pe_cnt[0] - pe0, 0);
      check_eq("drain_fd", fd_cnt[0] - fd0, 1);

      // Live load tracks buttons; pulse during latch flags an error
      set_buttons(0, 16'h0000);
      @(negedge clk);
      set_latch(0, 1'b1);
      repeat (6) @(negedge clk);
      check_eq("live_state", st_of(0), 1);
      check_eq("live_track0", data_of(0), 1);
      set_buttons(0, 16'h0001);
      repeat (4) @(negedge clk);
      pe0 = pe_cnt[0];
      pulse_bit(0, 1'b0, 1'b0, "ld_pulse");
      check_eq("ld_perr", pe_cnt[0] - pe0, 1);
      set_latch(0, 1'b0);
      model_load(0, 16'h0001);
      repeat (4) @(negedge clk);
      check_eq("live_first", data_of(0), 0);
      check_eq("live_bc", bc_of(0), 0);
      check_eq("live_shift", st_of(0), 2);
      shift_pulse(0, "live_b1");
      check_eq("live_perr", pe_cnt[0] - pe0, 1);

      // Timeout abandons the frame
      do_latch(0, 6, 16'h00FF);
      repeat (3) shift_pulse(0, "tmo_bit");
      pe0 = pe_cnt[0];
      repeat (TMO - 30) @(negedge clk);
      check_eq("tmo_not_yet", st_of(0), 2);
      check_eq("tmo_no_err", pe_cnt[0] - pe0, 0);
      repeat (40) @(negedge clk);
      check_eq("tmo_perr", pe_cnt[0] - pe0, 1);
      check_eq("tmo_state", st_of(0), 0);
      check_eq("tmo_data", data_of(0), 1);
      check_eq("tmo_bc", bc_of(0), 0);

      // New latch mid-frame restarts without error
      do_latch(0, 6, 16'h005A);
      repeat (3) shift_pulse(0, "rs_bit");
      pe0 = pe_cnt[0];
      set_latch(0, 1'b1);
      repeat (4) @(negedge clk);
      check_eq("rs_bc", bc_of(0), 0);
      check_eq("rs_load", st_of(0), 1);
      set_latch(0, 1'b0);
      model_load(0, 16'h005A);
      repeat (4) @(negedge clk);
      check_eq("rs_first", data_of(0), m[0][0]);
      check_eq("rs_state", st_of(0), 2);
      check_eq("rs_perr", pe_cnt[0] - pe0, 0);
      shift_pulse(0, "rs_b1");

      // SNES full frame
      do_latch(1, 12, 16'hA5C3);
      check_eq("snes_bit0", data_of(1), m[1][0]);
      fd0 = fd_cnt[1];
      repeat (16) shift_pulse(1, "snes_bit");
      check_eq("snes_fd_once", fd_cnt[1] - fd0, 1);
      check_eq("snes_bc", bc_of(1), 16);
      check_eq("snes_drained", st_of(1), 3);

      // Async reset mid-frame
      do_latch(1, 12, 16'hA5C3);
      repeat (7) shift_pulse(1, "snes_pre_rst");
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_data", data_of(1), 1);
      check_eq("arst_bc", bc_of(1), 0);
      check_eq("arst_fd", s_if.frame_done, 0);
      check_eq("arst_pe", s_if.proto_err, 0);
      check_eq("arst_state", st_of(1), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      pulse_bit(1, 1'b1, 1'b1, "post_rst_data");
      check_eq("post_rst_state", st_of(1), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Device-side model of the NES/SNES serial controller protocol: answers the latch/pulse strobes issued by the graphics top-level's controller reader with serial button data, exactly as a physical pad would.
- Used in benches and for board loopback so the controller reader and game-state logic can run without hardware.
- Single clock domain; host strobes are asynchronous and are synchronised internally.

Parameters:
- NUM_BITS, 8, buttons per frame (8 = NES, 16 = SNES); legal range 1..16.
- FILL, 1'b0, wire level driven after all NUM_BITS bits are shifted out.
- TIMEOUT, 4096, clk cycles without a pulse edge in SHIFT before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ctrl_latch  in  1  host latch strobe, asynchronous, active-high.
- ctrl_pulse  in  1  host shift clock, asynchronous, active on rising edge.
- buttons  in  NUM_BITS  pressed = 1; bit 0 (A) is sent first.
- ctrl_data  out  1  serial data on the wire, active-low (pressed = 0).
- bit_count  out  5  bits shifted in the current frame, saturating at NUM_BITS.
- frame_done  out  1  1-cycle pulse when the last bit has been shifted.
- proto_err  out  1  1-cycle pulse on a protocol violation.
- state  out  2  FSM state: IDLE=0, LOAD=1, SHIFT=2, DRAINED=3.

Behaviour:
- Reset (async assert, sync release):
  - sreg = all 1s; ctrl_data = 1; bit_count = 0; frame_done = 0; proto_err = 0; state = IDLE; timeout counter = 0.
- Input conditioning:
  - ctrl_latch and ctrl_pulse each pass through a 2-flop synchroniser (latch_s, pulse_s).
  - pulse_rise = pulse_s & ~pulse_d, where pulse_d is one further register stage.
- Data path:
  - sreg is NUM_BITS wide and holds inverted buttons; ctrl_data = sreg[0], registered.
  - A shift is a right shift with FILL inserted at the MSB.
- Latency:
  - A pin edge first sampled at clk edge k changes ctrl_data at edge k+3.
- FSM (evaluated each clk; latch_s has top priority in every state):
  - Any state, latch_s = 1 → LOAD.
  - LOAD: sreg <= ~buttons every cycle (transparent load, tracks live buttons); bit_count = 0.
    - latch_s falls → SHIFT; sreg holds the last value loaded.
    - pulse_rise while latch_s = 1 → ignored, proto_err pulse.
  - SHIFT: on pulse_rise → shift sreg, bit_count++, timeout counter cleared.
    - If bit_count becomes NUM_BITS → DRAINED; frame_done pulses in the same cycle as the final increment.
    - TIMEOUT consecutive cycles without pulse_rise → IDLE; proto_err pulse; sreg = all 1s; bit_count = 0.
  - DRAINED: pulse_rise continues to shift (ctrl_data stays FILL); bit_count stays at NUM_BITS; no error.
  - IDLE: pulse_rise ignored; ctrl_data stays 1.
- Simultaneous events:
  - latch_s falling in the same cycle as pulse_rise: go to SHIFT without shifting; no error.
  - pulse_rise in the same cycle as the timeout expiry: the shift wins and the counter clears.
- Mid-operation events:
  - Reset asserted mid-frame immediately forces reset values; the first frame after release needs a new latch.
  - A new latch mid-frame restarts the frame; no error.
- Width:
  - bit_count is 5 bits, zero-extended.
  - Timeout counter is sized to clog2(TIMEOUT+1) and saturates.
- All outputs are registered.

Test Plan:
- Reset then idle: hold reset low 5 cycles, release, toggle ctrl_pulse 4x without a latch → ctrl_data=1 throughout, state=0, proto_err never asserts.
- Basic NES frame: buttons=8'b1000_0101, latch 12 cycles then release, 8 pulses (6 cycles high/6 low) → ctrl_data sequence 0,1,0,1,1,1,1,0; frame_done pulses once after the 8th pulse; bit_count=8.
- Drain and latency: 2 extra pulses after frame → ctrl_data=FILL (0), bit_count stays 8; measure each ctrl_data change exactly 3 clk after pulse sampled.
- Live load: change buttons from 8'h00 to 8'h01 while latch is high, drop latch → first bit is 0 (pressed); pulse during latch → proto_err single-cycle pulse, sreg unchanged by it.
- Timeout and restart: latch, 3 pulses, then silence for TIMEOUT+2 cycles → proto_err pulse, state=IDLE, ctrl_data=1; new latch mid-SHIFT in another run → bit_count=0, no error.
- SNES config (NUM_BITS=16): buttons=16'hA5C3, full frame → 16 bits LSB-first inverted, frame_done after the 16th pulse; async reset asserted after bit 7 → all outputs return to reset values within the same cycle.
